quad_encoder_bank: RTL and testbench

//  N-channel quadrature rotary-encoder front end for the display-board dials, and a parametrised successor to the single-dial decoder.
//  Per channel: input synchroniser, debounce filter, Gray-code step decoder, sub-step accumulator, position counter (wrap or saturate), load.

---
 rtl/quad_pkg.sv | 43 ++++
 rtl/quad_channel.sv | 144 ++++++++++++++
 rtl/quad_encoder_bank.sv | 43 ++++
 tb/tb_quad_encoder_bank.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared types and helpers for the quadrature encoder bank.
package quad_pkg;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_CW,
    DIR_CCW,
    DIR_ERR
  } dir_t;

  localparam int unsigned NUM_LEGAL_CPS = 3;
  localparam int unsigned LEGAL_CPS [NUM_LEGAL_CPS] = '{1, 2, 4};

  // True when cps is one of the supported detent scalings.
  function automatic logic cps_legal(input int unsigned cps);
    logic ok;
    ok = 1'b0;
    for (int unsigned i = 0; i < NUM_LEGAL_CPS; i++) begin
      if (LEGAL_CPS[i] == cps) ok = 1'b1;
    end
    return ok;
  endfunction

  // Position of a Gray code on the clockwise cycle 00->01->11->10.
  function automatic logic [1:0] gray_pos(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  // Classify a prev->cur transition of the {A,B} pair.
  function automatic dir_t quad_decode(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] p;
    logic [1:0] c;
    dir_t       d;
    p = gray_pos(prev);
    c = gray_pos(cur);
    if (prev == cur)                 d = DIR_NONE;
    else if ((prev ^ cur) == 2'b11)  d = DIR_ERR;
    else if (c == 2'(p + 2'd1))      d = DIR_CW;
    else                             d = DIR_CCW;
    return d;
  endfunction

endpackage

// File: rtl/quad_channel.sv
// One encoder channel: synchroniser, per-bit debounce, priming, Gray decode,
// sub-step accumulator, position counter with load, sticky illegal flag.
module quad_channel
  import quad_pkg::*;
#(
  parameter int unsigned POS_W           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned COUNTS_PER_STEP = 4,
  parameter bit          WRAP            = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       quad_in,
  input  logic             load_en,
  input  logic [POS_W-1:0] load_val,
  input  logic             err_clr,
  output logic [POS_W-1:0] pos,
  output logic             cw,
  output logic             ccw,
  output logic             err
);

  if (!cps_legal(COUNTS_PER_STEP)) begin : g_bad_cps
    $error("quad_channel: COUNTS_PER_STEP must be 1, 2 or 4");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("quad_channel: DEBOUNCE_CYCLES must be at least 1");
  end

  localparam int unsigned CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned PRIME_W = $clog2(DEBOUNCE_CYCLES + 2);

  localparam logic [CNT_W-1:0]   DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  // The priming window also covers the two synchroniser stages.
  localparam logic [PRIME_W-1:0] PRIME_END = PRIME_W'(DEBOUNCE_CYCLES + 1);
  localparam logic signed [3:0]  ACC_TOP   = 4'(COUNTS_PER_STEP);
  localparam logic signed [3:0]  ACC_BOT   = -ACC_TOP;

  logic [1:0]         sync1, sync2;
  logic [1:0]         filt;
  logic [CNT_W-1:0]   db_cnt [2];
  logic               primed;
  logic [PRIME_W-1:0] prime_cnt;
  logic               prime_now;
  logic [1:0]         prev;
  logic signed [3:0]  acc, acc_n;
  logic               cw_step, ccw_step;
  logic [POS_W-1:0]   pos_step;
  dir_t               dir;

  assign prime_now = !primed && (prime_cnt == PRIME_END);

  // Two-flop synchroniser on the asynchronous encoder pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= quad_in;
      sync2 <= sync1;
    end
  end

  // Priming window after reset, then independent per-bit debounce.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt      <= '0;
      primed    <= 1'b0;
      prime_cnt <= '0;
      for (int unsigned b = 0; b < 2; b++) db_cnt[b] <= '0;
    end else if (!primed) begin
      if (prime_now) begin
        filt   <= sync2;
        primed <= 1'b1;
      end else begin
        prime_cnt <= prime_cnt + 1'b1;
      end
    end else begin
      for (int unsigned b = 0; b < 2; b++) begin
        if (sync2[b] != filt[b]) begin
          if (db_cnt[b] == DB_LAST) begin
            filt[b]   <= sync2[b];
            db_cnt[b] <= '0;
          end else begin
            db_cnt[b] <= db_cnt[b] + 1'b1;
          end
        end else begin
          db_cnt[b] <= '0;
        end
      end
    end
  end

  // Decode the accepted transition and derive accumulator and position updates.
  always_comb begin
    dir      = primed ? quad_decode(prev, filt) : DIR_NONE;
    acc_n    = acc;
    cw_step  = 1'b0;
    ccw_step = 1'b0;
    pos_step = pos;
    case (dir)
      DIR_CW: begin
        if (acc + 4'sd1 == ACC_TOP) begin
          cw_step = 1'b1;
          acc_n   = '0;
        end else begin
          acc_n = acc + 4'sd1;
        end
      end
      DIR_CCW: begin
        if (acc - 4'sd1 == ACC_BOT) begin
          ccw_step = 1'b1;
          acc_n    = '0;
        end else begin
          acc_n = acc - 4'sd1;
        end
      end
      default: ;
    endcase
    if (cw_step && (WRAP || pos != '1))  pos_step = pos + POS_W'(1);
    if (ccw_step && (WRAP || pos != '0)) pos_step = pos - POS_W'(1);
  end

  // Step state, outputs and sticky error; load overrides a simultaneous step.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= '0;
      acc  <= '0;
      pos  <= '0;
      cw   <= 1'b0;
      ccw  <= 1'b0;
      err  <= 1'b0;
    end else begin
      if (prime_now)             prev <= sync2;
      else if (dir != DIR_NONE)  prev <= filt;
      acc <= acc_n;
      cw  <= cw_step;
      ccw <= ccw_step;
      pos <= load_en ? load_val : pos_step;
      err <= (dir == DIR_ERR) | (err & ~err_clr);
    end
  end

endmodule

// File: rtl/quad_encoder_bank.sv
// N-channel quadrature encoder front end; one independent quad_channel per dial.
module quad_encoder_bank
  import quad_pkg::*;
#(
  parameter int unsigned CHANNELS        = 2,
  parameter int unsigned POS_W           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned COUNTS_PER_STEP = 4,
  parameter bit          WRAP            = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2*CHANNELS-1:0]     quad_in,
  input  logic [CHANNELS-1:0]       load_en,
  input  logic [POS_W-1:0]          load_val,
  input  logic [CHANNELS-1:0]       err_clr,
  output logic [POS_W*CHANNELS-1:0] pos,
  output logic [CHANNELS-1:0]       cw,
  output logic [CHANNELS-1:0]       ccw,
  output logic [CHANNELS-1:0]       err
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    quad_channel #(
      .POS_W           (POS_W),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .COUNTS_PER_STEP (COUNTS_PER_STEP),
      .WRAP            (WRAP)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .quad_in  (quad_in[2*i +: 2]),
      .load_en  (load_en[i]),
      .load_val (load_val),
      .err_clr  (err_clr[i]),
      .pos      (pos[i*POS_W +: POS_W]),
      .cw       (cw[i]),
      .ccw      (ccw[i]),
      .err      (err[i])
    );
  end

endmodule

// File: tb/tb_quad_encoder_bank.sv
// Bench for quad_encoder_bank: directed vector table, hand-written latency/load/reset
// sequences, and random stimulus against a behavioural model (wrapping and saturating DUTs).
module tb_quad_encoder_bank;

  localparam int D   = 4;
  localparam int CPS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  quad_in;
  logic [1:0]  load_en;
  logic [7:0]  load_val;
  logic [1:0]  err_clr;
  logic [15:0] pos,  pos_s;
  logic [1:0]  cw,   cw_s;
  logic [1:0]  ccw,  ccw_s;
  logic [1:0]  err,  err_s;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  quad_encoder_bank #(.CHANNELS(2), .POS_W(8), .DEBOUNCE_CYCLES(D),
                      .COUNTS_PER_STEP(CPS), .WRAP(1'b1)) dut (
    .clk(clk), .rst(rst), .quad_in(quad_in), .load_en(load_en), .load_val(load_val),
    .err_clr(err_clr), .pos(pos), .cw(cw), .ccw(ccw), .err(err));

  quad_encoder_bank #(.CHANNELS(2), .POS_W(8), .DEBOUNCE_CYCLES(D),
                      .COUNTS_PER_STEP(CPS), .WRAP(1'b0)) dut_sat (
    .clk(clk), .rst(rst), .quad_in(quad_in), .load_en(load_en), .load_val(load_val),
    .err_clr(err_clr), .pos(pos_s), .cw(cw_s), .ccw(ccw_s), .err(err_s));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Clockwise cycle position of each code.
  function automatic int cpos(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] code_at(input int p);
    case (p % 4)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  bit         model_valid = 0;
  logic [1:0] m_d1 [2], m_d2 [2];   // input as seen one / two edges ago
  logic [1:0] m_acpt [2];           // debounced value
  logic [1:0] m_last [2];           // last decoded value
  int         m_run [2][2];         // consecutive edges a bit disagreed
  bit         m_primed [2];
  int         m_since [2];
  int         m_sub [2];
  int         m_pos [2][2];         // [0]=wrapping dut, [1]=saturating dut
  bit         m_err [2], m_cw [2], m_ccw [2];

  // Advance the reference model by one clock edge.
  always @(posedge clk) begin
    int  step;
    bit  ill;
    if (rst) begin
      model_valid = 1;
      for (int c = 0; c < 2; c++) begin
        m_d1[c] = 0; m_d2[c] = 0; m_acpt[c] = 0; m_last[c] = 0;
        m_run[c][0] = 0; m_run[c][1] = 0; m_primed[c] = 0; m_since[c] = 0;
        m_sub[c] = 0; m_pos[0][c] = 0; m_pos[1][c] = 0;
        m_err[c] = 0; m_cw[c] = 0; m_ccw[c] = 0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        m_cw[c] = 0; m_ccw[c] = 0; ill = 0;
        if (m_primed[c] && m_acpt[c] != m_last[c]) begin
          step = (cpos(m_acpt[c]) - cpos(m_last[c]) + 4) % 4;
          if (step == 2) ill = 1;
          else if (step == 1) begin
            m_sub[c]++;
            if (m_sub[c] == CPS) begin m_sub[c] = 0; m_cw[c] = 1; end
          end else begin
            m_sub[c]--;
            if (m_sub[c] == -CPS) begin m_sub[c] = 0; m_ccw[c] = 1; end
          end
          m_last[c] = m_acpt[c];
        end
        for (int w = 0; w < 2; w++) begin
          if (load_en[c]) m_pos[w][c] = int'(load_val);
          else if (m_cw[c])
            m_pos[w][c] = (w == 0) ? (m_pos[w][c] + 1) % 256 : (m_pos[w][c] < 255 ? m_pos[w][c] + 1 : 255);
          else if (m_ccw[c])
            m_pos[w][c] = (w == 0) ? (m_pos[w][c] + 255) % 256 : (m_pos[w][c] > 0 ? m_pos[w][c] - 1 : 0);
        end
        m_err[c] = ill | (m_err[c] & !err_clr[c]);
        if (!m_primed[c]) begin
          m_since[c]++;
          if (m_since[c] == D + 2) begin
            m_acpt[c] = m_d2[c]; m_last[c] = m_d2[c]; m_primed[c] = 1;
          end
        end else begin
          for (int b = 0; b < 2; b++) begin
            if (m_d2[c][b] != m_acpt[c][b]) begin
              m_run[c][b]++;
              if (m_run[c][b] == D) begin m_acpt[c][b] = m_d2[c][b]; m_run[c][b] = 0; end
            end else m_run[c][b] = 0;
          end
        end
        m_d2[c] = m_d1[c];
        m_d1[c] = quad_in[2*c +: 2];
      end
    end
  end

  // Compare both DUTs with the model on every falling edge.
  always @(negedge clk) begin
    if (model_valid) begin
      chk("model_pos",     {16'h0, pos},   {16'h0, 8'(m_pos[0][1]), 8'(m_pos[0][0])});
      chk("model_pos_sat", {16'h0, pos_s}, {16'h0, 8'(m_pos[1][1]), 8'(m_pos[1][0])});
      chk("model_cw",      {28'h0, cw, cw_s},   {28'h0, m_cw[1], m_cw[0], m_cw[1], m_cw[0]});
      chk("model_ccw",     {28'h0, ccw, ccw_s}, {28'h0, m_ccw[1], m_ccw[0], m_ccw[1], m_ccw[0]});
      chk("model_err",     {28'h0, err, err_s}, {28'h0, m_err[1], m_err[0], m_err[1], m_err[0]});
    end
  end

  // ---------------- directed table ----------------
  typedef struct {
    logic        rst;
    logic [3:0]  quad;
    logic [1:0]  err_clr;
    int          cyc;
    logic [15:0] epos;
    logic [15:0] epos_sat;
    logic [1:0]  eerr;
    int          ecw0, eccw0;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [3:0] q, input logic [1:0] ec, input int n,
                              input logic [15:0] p, input logic [15:0] ps, input logic [1:0] e,
                              input int c0, input int cc0);
    vec_t v;
    v.rst = r; v.quad = q; v.err_clr = ec; v.cyc = n; v.epos = p; v.epos_sat = ps;
    v.eerr = e; v.ecw0 = c0; v.eccw0 = cc0;
    return v;
  endfunction

  vec_t vt [$];

  initial begin
    int pc [4];
    logic [1:0] cur, nxt;
    int hold, r;

    rst = 1'b1; quad_in = 4'hF; load_en = '0; load_val = '0; err_clr = '0;

    vt.push_back(mk(1, 4'hF, 2'b00,  3, 16'h0000, 16'h0000, 2'b00, 0, 0)); // reset
    vt.push_back(mk(0, 4'hF, 2'b00, 20, 16'h0000, 16'h0000, 2'b00, 0, 0)); // priming only
    vt.push_back(mk(0, 4'hE, 2'b00,  8, 16'h0000, 16'h0000, 2'b00, 0, 0)); // ch0 CW 11->10
    vt.push_back(mk(0, 4'hC, 2'b00,  8, 16'h0000, 16'h0000, 2'b00, 0, 0));
    vt.push_back(mk(0, 4'hD, 2'b00,  8, 16'h0000, 16'h0000, 2'b00, 0, 0));
    vt.push_back(mk(0, 4'hF, 2'b00,  8, 16'h0001, 16'h0001, 2'b00, 1, 0)); // one cw step
    vt.push_back(mk(0, 4'hD, 2'b00,  8, 16'h0001, 16'h0001, 2'b00, 0, 0)); // reverse
    vt.push_back(mk(0, 4'hC, 2'b00,  8, 16'h0001, 16'h0001, 2'b00, 0, 0));
    vt.push_back(mk(0, 4'hE, 2'b00,  8, 16'h0001, 16'h0001, 2'b00, 0, 0));
    vt.push_back(mk(0, 4'hF, 2'b00,  8, 16'h0000, 16'h0000, 2'b00, 0, 1)); // one ccw step
    vt.push_back(mk(0, 4'hD, 2'b00,  8, 16'h0000, 16'h0000, 2'b00, 0, 0)); // ccw from 0
    vt.push_back(mk(0, 4'hC, 2'b00,  8, 16'h0000, 16'h0000, 2'b00, 0, 0));
    vt.push_back(mk(0, 4'hE, 2'b00,  8, 16'h0000, 16'h0000, 2'b00, 0, 0));
    vt.push_back(mk(0, 4'hF, 2'b00,  8, 16'h00FF, 16'h0000, 2'b00, 0, 1)); // wrap vs hold
    vt.push_back(mk(0, 4'hD, 2'b00,  3, 16'h00FF, 16'h0000, 2'b00, 0, 0)); // 3-cycle glitch on A
    vt.push_back(mk(0, 4'hF, 2'b00, 10, 16'h00FF, 16'h0000, 2'b00, 0, 0));
    vt.push_back(mk(0, 4'hC, 2'b00,  8, 16'h00FF, 16'h0000, 2'b01, 0, 0)); // 11->00 illegal
    vt.push_back(mk(0, 4'hC, 2'b01,  1, 16'h00FF, 16'h0000, 2'b00, 0, 0)); // err_clr
    vt.push_back(mk(0, 4'hC, 2'b00,  4, 16'h00FF, 16'h0000, 2'b00, 0, 0));
    vt.push_back(mk(0, 4'h8, 2'b00,  8, 16'h00FF, 16'h0000, 2'b00, 0, 0)); // ch1 CW partial
    vt.push_back(mk(0, 4'h0, 2'b00,  8, 16'h00FF, 16'h0000, 2'b00, 0, 0));
    vt.push_back(mk(0, 4'h4, 2'b00,  8, 16'h00FF, 16'h0000, 2'b00, 0, 0));

    foreach (vt[i]) begin
      rst = vt[i].rst; quad_in = vt[i].quad; err_clr = vt[i].err_clr;
      pc = '{0, 0, 0, 0};
      for (int k = 0; k < vt[i].cyc; k++) begin
        @(posedge clk); #1;
        pc[0] += int'(cw[0]); pc[1] += int'(ccw[0]); pc[2] += int'(cw[1]); pc[3] += int'(ccw[1]);
      end
      chk($sformatf("vec%0d_pos", i),     {16'h0, pos},   {16'h0, vt[i].epos});
      chk($sformatf("vec%0d_pos_sat", i), {16'h0, pos_s}, {16'h0, vt[i].epos_sat});
      chk($sformatf("vec%0d_err", i),     {30'h0, err},   {30'h0, vt[i].eerr});
      chk($sformatf("vec%0d_pulses", i),  pc[0] << 24 | pc[1] << 16 | pc[2] << 8 | pc[3],
          vt[i].ecw0 << 24 | vt[i].eccw0 << 16);
    end
    err_clr = '0;

    // Final ch1 CW edge: exact latency, with a load landing on the step edge.
    quad_in = 4'hC;
    for (int k = 1; k <= D + 2; k++) begin
      @(posedge clk); #1;
      chk($sformatf("lat_early_cw_e%0d", k), {30'h0, cw}, 32'h0);
      chk($sformatf("lat_early_pos_e%0d", k), {16'h0, pos}, 32'h00FF);
    end
    load_en = 2'b10; load_val = 8'h7F;
    @(posedge clk); #1;
    chk("load_step_cw",      {28'h0, cw, cw_s}, 32'hA);
    chk("load_step_pos",     {16'h0, pos},   32'h7FFF);
    chk("load_step_pos_sat", {16'h0, pos_s}, 32'h7F00);
    load_en = '0;
    @(posedge clk); #1;
    chk("pulse_one_cycle", {30'h0, cw}, 32'h0);

    // Reset in the middle of a debounce window, then re-prime.
    quad_in = 4'hD;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_pos", {16'h0, pos, pos_s} >> 16, 32'h0);
    chk("midrst_pos2", {16'h0, pos_s}, 32'h0);
    chk("midrst_flags", {24'h0, cw, ccw, err, cw_s}, 32'h0);
    rst = 1'b0;
    pc = '{0, 0, 0, 0};
    repeat (20) begin @(posedge clk); #1; pc[0] += int'(cw != 0 || ccw != 0); end
    chk("reprime_no_pulse", pc[0], 0);
    chk("reprime_pos", {16'h0, pos}, 32'h0);

    // Random stimulus; checked continuously by the model comparator.
    for (int it = 0; it < 300; it++) begin
      for (int c = 0; c < 2; c++) begin
        cur = quad_in[2*c +: 2];
        r = $urandom_range(0, 9);
        if (r <= 5)      nxt = code_at(cpos(cur) + (($urandom_range(0, 1) == 1) ? 1 : 3));
        else if (r == 6) nxt = ~cur;
        else             nxt = cur;
        quad_in[2*c +: 2] = nxt;
      end
      load_en  = {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)};
      load_val = 8'($urandom_range(0, 255));
      err_clr  = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
      rst      = ($urandom_range(0, 149) == 0);
      hold     = $urandom_range(1, 12);
      @(posedge clk); #1;
      load_en = '0; err_clr = '0; rst = 1'b0;
      repeat (hold - 1) begin @(posedge clk); #1; end
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
